mdu_divider: RTL and testbench
==============================

Name: mdu_divider

Overview:
- Iterative 32-bit radix-2 restoring divider in the EX stage.
- Serves the responder side of the hazard unit's div_start/div_ready handshake; the hazard unit asserts div_start while EX holds DIV/DIVU and div_ready is low, and stalls IF/ID/EX meanwhile.
- Produces {HI=remainder, LO=quotient} for the HI/LO write path.
- Also honours pipeline flush (annul) and downstream stall (hold), so a finished result is neither lost nor recomputed.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is verified.

Ports:
- clk  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- div_start  in  1  request from hazard unit; high while EX holds DIV/DIVU and div_ready=0
- div_signed  in  1  1=DIV (signed), 0=DIVU; sampled with the operands
- opdata1  in  WIDTH  dividend (rs); sampled only on acceptance
- opdata2  in  WIDTH  divisor (rt); sampled only on acceptance
- annul  in  1  EX flush (exception); aborts any operation in progress
- hold  in  1  EX cannot advance this cycle (stallreq_from_mem)
- div_ready  out  1  result valid; high for the whole DONE state
- div_result  out  2*WIDTH  [63:32]=remainder (HI), [31:0]=quotient (LO)

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, div_ready=0, div_result=0, counter=0, internal regs=0.
- States and transitions:
  - IDLE: div_ready=0. If div_start=1 and annul=0 at a rising edge, accept:
    - latch div_signed;
    - latch |opdata1| and |opdata2| (absolute values when signed, raw when unsigned);
    - latch quotient sign = op1[31]^op2[31] and remainder sign = op1[31] (signed only);
    - clear the partial remainder, set counter=0, go to BUSY.
  - BUSY: one restoring iteration per edge:
    - shift {rem,quo} left by 1 and trial-subtract the divisor;
    - if no borrow, keep the difference and set quo[0]=1;
    - counter increments. On the edge completing iteration 32 (counter==31), apply sign correction (negate quotient/remainder per the latched signs), register div_result, go to DONE.
  - DONE: div_ready=1 and div_result stable. If hold=0 at an edge, go to IDLE (the instruction leaves EX). If hold=1, stay in DONE. While div_ready=1, div_start is low by construction, so no restart.
- Latency:
  - Accept edge E0; result registered at edge E32; div_ready high from E32 onward.
  - The hazard unit therefore stalls EX for 33 cycles (cycle of E0 through cycle before E32) plus any hold.
- annul=1 at any edge, in any state: go to IDLE, div_ready=0 next cycle, div_result unchanged. annul has priority over every transition, including accept and DONE exit.
- div_start dropping during BUSY without annul: ignored; computation continues to DONE (hazard never does this).
- Operand changes after acceptance are ignored.
- Divide by zero (divisor=0): no exception and no early exit; the natural restoring result stands.
  - Unsigned: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed: sign correction is applied to that magnitude result.
  - Always 32 iterations.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. Absolute value of 0x80000000 is treated as unsigned 2^31.
- Remainder sign always follows the dividend; |remainder| < |divisor| for a nonzero divisor.
- No back-to-back accept: at least one IDLE cycle separates operations.

Decomposition:
- defines.vh (shared include):
  - state encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE` (2-bit);
  - `DIV_ITERS` = 32.
- One combinational sub-module, div_step:
  - inputs: partial remainder, quotient, divisor;
  - outputs: next remainder and quotient after one shift/trial-subtract.
  - Keeps the iteration logic separately testable.
- Sign handling and the FSM stay in mdu_divider.

Test Plan:
- Unsigned 100/7 (div_signed=0, start held until ready) -> div_ready rises exactly 32 edges after accept; div_result={0x00000002,0x0000000E}; ready falls the cycle after hold=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000/0xFFFFFFFF -> {0x00000000,0x80000000}. Unsigned 0x12345678/0 -> {0x12345678,0xFFFFFFFF}; latency unchanged.
- annul pulsed at edge 10 of BUSY -> IDLE, div_ready never asserts, div_result retains its previous value. A new start next cycle (200/10) -> {0,20} after 32 edges.
- hold=1 for 5 cycles while DONE -> div_ready stays 1, div_result stable, no re-accept. hold=0 -> IDLE next edge.
- resetn pulsed low mid-BUSY (asynchronous, between edges) -> div_ready=0 and div_result=0 immediately. After release, a fresh 9/3 -> {0,3}.

Source files
------------

// File: rtl/mdu_divider_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
package mdu_divider_pkg;

  // One restoring iteration per quotient bit of a 32-bit operand.
  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_divider_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract divisor.
module mdu_divider_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic             no_borrow;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs one extra bit; a successful difference always fits WIDTH bits.
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    no_borrow = (shifted >= {1'b0, divisor});
    diff      = shifted[WIDTH-1:0] - divisor;
    rem_next  = shifted[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], 1'b0};
    if (no_borrow) begin
      rem_next = diff;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_divider.sv
// EX-stage 32-iteration restoring divider answering the hazard unit's div_start/div_ready handshake.
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITERS
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  input  logic               hold,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] div_result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] op1_abs, op2_abs;
  logic [WIDTH-1:0] res_rem, res_quo;
  logic             signed_q, q_neg_q, r_neg_q;
  logic             accept, step, finish;

  mdu_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // Operand magnitudes; 0x80000000 negates to itself and is read as unsigned 2^31.
  always_comb begin
    op1_abs = (div_signed && opdata1[WIDTH-1]) ? (~opdata1 + WIDTH'(1)) : opdata1;
    op2_abs = (div_signed && opdata2[WIDTH-1]) ? (~opdata2 + WIDTH'(1)) : opdata2;
  end

  // Sign correction of the final iteration's magnitudes; remainder follows the dividend.
  always_comb begin
    res_quo = (signed_q && q_neg_q) ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
    res_rem = (signed_q && r_neg_q) ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
  end

  // Next-state and datapath strobes; annul overrides every transition.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (div_start) begin
          accept    = 1'b1;
          state_nxt = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          finish    = 1'b1;
          state_nxt = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (!hold) state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
    if (annul) begin
      state_nxt = DIV_IDLE;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_nxt;
  end

  // Operand capture on accept, then one shift/subtract per BUSY cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt      <= '0;
    end else if (accept) begin
      signed_q <= div_signed;
      q_neg_q  <= opdata1[WIDTH-1] ^ opdata2[WIDTH-1];
      r_neg_q  <= opdata1[WIDTH-1];
      rem_q    <= '0;
      quo_q    <= op1_abs;
      dvs_q    <= op2_abs;
      cnt      <= '0;
    end else if (step) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // Registered handshake and result; the result holds until the next completion or reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_ready  <= 1'b0;
      div_result <= '0;
    end else begin
      div_ready <= (state_nxt == DIV_DONE);
      if (finish) div_result <= {res_rem, res_quo};
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Randomized and directed checks of mdu_divider against an arithmetic reference.
module tb_mdu_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        hold;
  logic        div_ready;
  logic [63:0] div_result;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] last_res;

  mdu_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .hold       (hold),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  // Reference: {remainder, quotient} from plain integer division.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint la, lb;
    if (b == 32'd0) begin
      // magnitudes: quotient all ones, remainder |a|; both negated when a is negative (signed)
      r = a;
      q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = 32'(la / lb);
      r  = 32'(la % lb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the accept edge; operands then scramble.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_start  = 1'b1;
    div_signed = sgn;
    opdata1    = a;
    opdata2    = b;
    tick();
    opdata1    = $urandom;
    opdata2    = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!div_ready && lat < 100) begin
      tick();
      lat++;
    end
    div_start = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] exp;
    exp = ref_div(sgn, a, b);
    start_op(sgn, a, b);
    wait_ready(lat);
    n_cmp++;
    if (lat !== 32) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges, expected 32", nm, lat);
    end
    n_cmp++;
    if (div_result !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h expected %h (a=%h b=%h s=%0b)", nm, div_result, exp, a, b, sgn);
    end
    last_res = exp;
    tick();
    n_cmp++;
    if (div_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s ready_fall: got %b expected 0", nm, div_ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; div_start = 1'b0; div_signed = 1'b0; opdata1 = '0; opdata2 = '0;
    annul = 1'b0; hold = 1'b0;
    #12;
    n_cmp++;
    if (div_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", div_ready); end
    n_cmp++;
    if (div_result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", div_result); end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    check_op("u100_7", 1'b0, 32'd100, 32'd7);
    check_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    check_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    check_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("u_div0", 1'b0, 32'h1234_5678, 32'd0);
    check_op("s_div0", 1'b1, 32'hFFFF_FFF0, 32'd0);
  endtask

  task automatic test_random();
    logic        sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = (i % 7 == 3) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = 32'($urandom) >> $urandom_range(0, 31);
        default: b = 32'($urandom);
      endcase
      check_op("random", sgn, a, b);
    end
  endtask

  task automatic test_annul();
    bit seen;
    // annul with a request in IDLE blocks the accept
    div_start = 1'b1; div_signed = 1'b0; opdata1 = 32'd55; opdata2 = 32'd5; annul = 1'b1;
    tick();
    div_start = 1'b0; annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (div_ready) seen = 1'b1; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL annul_accept: ready asserted, expected never"); end
    // annul mid-BUSY aborts and leaves the previous result in place
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (9) tick();
    annul = 1'b1; div_start = 1'b0;
    tick();
    annul = 1'b0;
    n_cmp++;
    if (div_ready !== 1'b0) begin n_err++; $display("FAIL annul_ready: got %b expected 0", div_ready); end
    seen = 1'b0;
    repeat (40) begin tick(); if (div_ready) seen = 1'b1; end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL annul_busy: ready asserted, expected never"); end
    n_cmp++;
    if (div_result !== last_res) begin
      n_err++; $display("FAIL annul_result: got %h expected %h", div_result, last_res);
    end
    check_op("after_annul", 1'b0, 32'd200, 32'd10);
  endtask

  task automatic test_hold();
    int lat;
    logic [63:0] exp;
    exp = ref_div(1'b1, 32'hFFFF_D8F1, 32'd37);
    start_op(1'b1, 32'hFFFF_D8F1, 32'd37);
    wait_ready(lat);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (div_ready !== 1'b1 || div_result !== exp) begin
        n_err++;
        $display("FAIL hold_%0d: ready=%b result=%h expected ready=1 result=%h", i, div_ready, div_result, exp);
      end
    end
    hold = 1'b0;
    tick();
    n_cmp++;
    if (div_ready !== 1'b0) begin n_err++; $display("FAIL hold_release: got %b expected 0", div_ready); end
    last_res = exp;
  endtask

  task automatic test_reset_mid();
    start_op(1'b0, 32'd77, 32'd5);
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (div_ready !== 1'b0 || div_result !== 64'd0) begin
      n_err++;
      $display("FAIL async_reset: ready=%b result=%h expected 0/0 (prior result %h)", div_ready, div_result, last_res);
    end
    div_start = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check_op("after_reset", 1'b0, 32'd9, 32'd3);
  endtask

  initial begin
    last_res = '0;
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
